// File: rtl/sipo_frame_ctrl.sv
// Serial-in frame controller: start bit, WIDTH data bits MSB-first, optional even parity, word handshake out.
// Build option: define PARITY_CHECK_EN to add a parity bit after the data bits and the frame_err check.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             shift_en,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2, WAIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, WAIT = 2'd3} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wvld_q, wvld_d;
  logic             ferr_q, ferr_d;

  logic             accept;
  logic             slot_free;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shifted;

  // bit_ready follows the reset pin directly so it drops the instant reset asserts.
  assign bit_ready = reset && (state_q != WAIT);
  assign accept    = bit_valid && bit_ready;
  assign shift_en  = accept && (state_q == DATA);
  assign slot_free = !wvld_q || word_ready;
  assign shifted   = {shift_q[WIDTH-2:0], serial_in};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ferr_d    = 1'b0;
    load      = 1'b0;
    load_word = shift_q;
    case (state_q)
      IDLE: begin
        if (accept && !serial_in) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (accept) begin
          shift_d = shifted;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
            state_d = PAR;
`else
            if (slot_free) begin
              load      = 1'b1;
              load_word = shifted;
              state_d   = IDLE;
            end else begin
              state_d = WAIT;
            end
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (accept) begin
          // Even parity: data bits plus parity bit must XOR to zero.
          if (^{shift_q, serial_in} == 1'b0) begin
            if (slot_free) begin
              load    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      WAIT: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    word_d = load ? load_word : word_q;
    if (load)            wvld_d = 1'b1;
    else if (word_ready) wvld_d = 1'b0;
    else                 wvld_d = wvld_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      wvld_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      wvld_q  <= wvld_d;
      ferr_q  <= ferr_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = wvld_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4); frames carry a parity bit when PARITY_CHECK_EN is defined.
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             serial_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             shift_en;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             frame_err;

  int total = 0;
  int bad   = 0;
  int se_cnt;
  bit ferr_seen = 1'b0;

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .shift_en   (shift_en),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, note combinational strobes, then step past the posedge.
  task automatic drive_bit(input logic b, input logic v);
    @(negedge clk);
    serial_in = b;
    bit_valid = v;
    #1;
    if (shift_en === 1'b1) se_cnt++;
    @(posedge clk);
    #1;
    if (frame_err === 1'b1) ferr_seen = 1'b1;
  endtask

  task automatic idle_cycle();
    drive_bit(1'b0, 1'b0);
  endtask

  // Start bit, data MSB first, optional parity; gap inserts a bit_valid=0 cycle with a junk bit.
  task automatic send_frame(input logic [3:0] d, input bit gap);
    drive_bit(1'b0, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      if (gap) drive_bit(~d[i], 1'b0);
      drive_bit(d[i], 1'b1);
    end
`ifdef PARITY_CHECK_EN
    if (gap) drive_bit(1'b1, 1'b0);
    drive_bit(^d, 1'b1);
`endif
  endtask

  initial begin
    reset      = 1'b0;
    serial_in  = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b1;
    se_cnt     = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bit_ready", bit_ready, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_word_out", word_out, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_shift_en", shift_en, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_bit_ready", bit_ready, 1);

    // Basic frame 1011 with consumer always ready.
    se_cnt = 0;
    send_frame(4'b1011, 1'b0);
    chk("basic_word_valid", word_valid, 1);
    chk("basic_word_out", word_out, 4'b1011);
    chk("basic_shift_cnt", se_cnt, 4);
    idle_cycle();
    chk("basic_valid_one_cycle", word_valid, 0);

    // Same frame with bit_valid toggling each cycle.
    se_cnt = 0;
    send_frame(4'b1011, 1'b1);
    chk("gap_word_valid", word_valid, 1);
    chk("gap_word_out", word_out, 4'b1011);
    chk("gap_shift_cnt", se_cnt, 4);
    idle_cycle();
    chk("gap_valid_clear", word_valid, 0);

    // Backpressure: second frame parks in WAIT while the first word is held.
    word_ready = 1'b0;
    send_frame(4'b1011, 1'b0);
    chk("bp_first_valid", word_valid, 1);
    chk("bp_first_out", word_out, 4'b1011);
    send_frame(4'b0100, 1'b0);
    chk("bp_wait_bit_ready", bit_ready, 0);
    chk("bp_wait_valid", word_valid, 1);
    chk("bp_wait_hold_out", word_out, 4'b1011);
    idle_cycle();
    chk("bp_wait_hold_out2", word_out, 4'b1011);
    chk("bp_wait_bit_ready2", bit_ready, 0);
    @(negedge clk);
    word_ready = 1'b1;
    bit_valid  = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_release_out", word_out, 4'b0100);
    chk("bp_release_valid", word_valid, 1);
    chk("bp_release_bit_ready", bit_ready, 1);
    idle_cycle();
    chk("bp_drained_valid", word_valid, 0);

    // Reset mid-frame with an undelivered word pending.
    word_ready = 1'b0;
    send_frame(4'b1011, 1'b0);
    chk("mid_pending_valid", word_valid, 1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    @(negedge clk);
    reset     = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("mid_rst_valid", word_valid, 0);
    chk("mid_rst_out", word_out, 0);
    chk("mid_rst_bit_ready", bit_ready, 0);
    @(negedge clk);
    reset      = 1'b1;
    word_ready = 1'b1;
    se_cnt = 0;
    send_frame(4'b0100, 1'b0);
    chk("post_rst_out", word_out, 4'b0100);
    chk("post_rst_valid", word_valid, 1);
    chk("post_rst_shift_cnt", se_cnt, 4);
    idle_cycle();

    // Leading idle-line 1s are not start bits.
    se_cnt = 0;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    chk("lead_ones_no_valid", word_valid, 0);
    send_frame(4'b1111, 1'b0);
    chk("lead_ones_out", word_out, 4'b1111);
    chk("lead_ones_valid", word_valid, 1);
    chk("lead_ones_shift_cnt", se_cnt, 4);
    idle_cycle();

`ifdef PARITY_CHECK_EN
    // Bad parity: 1011 has odd weight, parity bit 0 fails.
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    chk("par_fail_err", frame_err, 1);
    chk("par_fail_valid", word_valid, 0);
    idle_cycle();
    chk("par_fail_err_pulse", frame_err, 0);
    chk("par_fail_still_invalid", word_valid, 0);
`else
    chk("no_par_frame_err", ferr_seen, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 4, data bits per frame (2..16).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; sole clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: serial_in  input  1  serial line bit, sampled when bit_valid=1 and bit_ready=1.
REQ-005 SHALL have port: bit_valid  input  1  serial_in qualifier from the bit source.
REQ-006 SHALL have port: bit_ready  output  1  controller can accept a bit this cycle.
REQ-007 SHALL have port: shift_en  output  1  shift strobe to the SIPO datapath; high exactly on cycles a data bit is accepted.
REQ-008 SHALL have port: word_out  output  WIDTH  completed frame word; first data bit in word_out[WIDTH-1].
REQ-009 SHALL have port: word_valid  output  1  word_out holds an undelivered word.
REQ-010 SHALL have port: word_ready  input  1  consumer accepts word_out when word_valid=1.
REQ-011 SHALL have port: frame_err  output  1  one-cycle pulse on parity failure.

Function
REQ-012 SHALL implement states IDLE, DATA, PAR, WAIT.
REQ-013 A bit SHALL be accepted only on a rising clk edge with bit_valid=1 and bit_ready=1; bit_valid=0 cycles SHALL leave state, count and shift register unchanged.
REQ-014 IDLE: accepted bit with serial_in=0 (start bit) -> DATA, bit count cleared; serial_in=1 ignored, stay IDLE; shift_en=0.
REQ-015 DATA: each accepted bit SHALL shift left into the internal WIDTH-bit register (new bit into LSB), increment count, assert shift_en combinationally that cycle.
REQ-016 DATA: on acceptance of the WIDTH-th data bit -> PAR if PARITY_CHECK_EN defined, else completion per REQ-018.
REQ-017 PAR: next accepted bit is the parity bit; shift_en=0; even parity over data+parity bit; pass -> completion per REQ-018; fail -> frame_err=1 for one cycle, word discarded, -> IDLE.
REQ-018 Completion: if output slot free (word_valid=0, or word_valid=1 and word_ready=1 that edge) SHALL load word_out, set word_valid on the same edge, -> IDLE; otherwise -> WAIT.
REQ-019 WAIT: bit_ready=0; on first edge with slot free, load word_out, word_valid=1, -> IDLE.
REQ-020 bit_ready SHALL be 1 in IDLE, DATA, PAR; 0 in WAIT and during reset.
REQ-021 word_valid SHALL clear on edge with word_ready=1 unless a new word loads that edge (then stays 1 with new data).
REQ-022 word_out SHALL be stable while word_valid=1 and word_ready=0.
REQ-023 Latency: word_valid rises on the edge accepting the final frame bit when slot free; no bubble between back-to-back frames.
REQ-024 Count SHALL be clog2(WIDTH+1) bits; no wrap beyond WIDTH.

Reset
REQ-025 reset=0 SHALL immediately force: state IDLE, count 0, shift register 0, word_out 0, word_valid 0, frame_err 0, shift_en 0, bit_ready 0.
REQ-026 Reset mid-frame SHALL discard the partial frame and any undelivered word.
REQ-027 After reset release, first accepted bit SHALL be treated as IDLE-state input.

Configuration
REQ-028 Macro PARITY_CHECK_EN defined: PAR state and parity check per REQ-017 present; frame = start + WIDTH data + parity.
REQ-029 PARITY_CHECK_EN undefined: PAR state absent, frame_err tied 0, frame = start + WIDTH data bits.

Verification (WIDTH=4)
REQ-030 Bits 0,1,0,1,1 with bit_valid=1, word_ready=1, macro off -> shift_en high 4 cycles, word_out=4'b1011, word_valid=1 one cycle.
REQ-031 Same frame with bit_valid toggling 1/0 each cycle -> identical word_out=4'b1011; shift_en only on bit_valid=1 data cycles.
REQ-032 word_ready=0, frames 1011 then 0100 -> second frame enters WAIT, bit_ready=0, word_out holds 1011; word_ready=1 one cycle -> word_out=0100, word_valid stays 1, bit_ready=1.
REQ-033 reset=0 asserted after 2 data bits -> word_valid=0, word_out=0 immediately; fresh frame 0,0,1,0,0 -> word_out=4'b0100.
REQ-034 Macro on: 0,1,0,1,1,1(parity) -> word_out=1011; 0,1,0,1,1,0 -> frame_err pulse, word_valid stays 0.
REQ-035 Leading 1s in IDLE (1,1,1, then 0,1,1,1,1) -> ignored; word_out=4'b1111.
